// File: rtl/proc_pkg.sv
// proc_pkg: shared fetch-stage types and constants
package proc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;
  localparam logic [31:0] NOP_EMPTY = 32'h0;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID handshake pipeline register with flush, load-enable and hold
module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc8,
  output logic        valid,
  output logic [31:0] instr_q,
  output logic [31:0] pc_q,
  output logic [31:0] pc8_q
);
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      instr_q <= '0;
      pc_q <= '0;
      pc8_q <= '0;
    end else begin
      valid <= flush ? 1'b0 : load ? 1'b1 : valid && !ready;
      if (load && !flush) begin
        instr_q <= instr;
        pc_q <= pc;
        pc8_q <= pc8;
      end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC/FSM owner feeding the IF/ID register; FETCH_HALT_EN enables halt on empty/out-of-range fetch
module fetch_stage
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_WORDS   = 128
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        ValidD,
  input  logic        ReadyD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus8D,
  output logic [31:0] FetchCount,
  output logic        Halted
);
  fetch_state_t state;
  logic adv, stop, load;
  if (RESET_VECTOR[1:0] != 2'b00 || IMEM_WORDS < 1) begin : g_bad_cfg
    $error("fetch_stage: RESET_VECTOR must be word aligned and IMEM_WORDS positive");
  end
  assign adv = !ValidD || ReadyD;
`ifdef FETCH_HALT_EN
  assign stop = Instr == NOP_EMPTY || PC >= 32'(IMEM_WORDS * 4);
  assign Halted = state == HALT;
`else
  assign stop = 1'b0;
  assign Halted = 1'b0;
`endif
  assign load = state == RUN && adv && !Redirect && !stop;
  always_ff @(posedge CLK)
    if (Reset) begin
      state <= BOOT;
      PC <= RESET_VECTOR;
    end else if (Redirect) begin
      state <= RUN;
      PC <= {RedirectTarget[31:2], 2'b00};
    end else if (state == BOOT) begin
      state <= RUN;
    end else if (state == RUN && adv) begin
      state <= stop ? HALT : RUN;
      PC <= stop ? PC : PC + PC_STEP;
    end
  // a transfer in the redirect cycle still counts: decode has already taken it
  always_ff @(posedge CLK)
    FetchCount <= Reset ? '0 : FetchCount + {31'b0, ValidD && ReadyD};
  if_id_reg u_if_id (
    .clk     (CLK),
    .rst     (Reset),
    .flush   (Redirect),
    .load    (load),
    .ready   (ReadyD),
    .instr   (Instr),
    .pc      (PC),
    .pc8     (PC + PC_READ_OFFSET),
    .valid   (ValidD),
    .instr_q (InstrD),
    .pc_q    (PCD),
    .pc8_q   (PCPlus8D)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven check of fetch_stage (default build) with a combinational memory model
module tb_fetch_stage;
  logic CLK = 1'b0, Reset, Redirect, ReadyD, ValidD, Halted;
  logic [31:0] PC, Instr, RedirectTarget, InstrD, PCD, PCPlus8D, FetchCount;
  logic [31:0] mem [128];
  int n_checks = 0, n_fail = 0;
  typedef struct {
    logic rdy, red;
    logic [31:0] tgt;
    logic v;
    logic [31:0] pcd, ins, pc8, pc, cnt;
  } vec_t;
  vec_t vt [21];
  fetch_stage dut (
    .CLK(CLK), .Reset(Reset), .PC(PC), .Instr(Instr), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .ValidD(ValidD), .ReadyD(ReadyD),
    .InstrD(InstrD), .PCD(PCD), .PCPlus8D(PCPlus8D), .FetchCount(FetchCount),
    .Halted(Halted)
  );
  always #5 CLK = ~CLK;
  assign Instr = mem[PC[8:2]];
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic chk_all(input string n, input logic v, input logic [31:0] pcd, input logic [31:0] ins,
                         input logic [31:0] pc8, input logic [31:0] pc, input logic [31:0] cnt);
    chk({n, " ValidD"}, {31'b0, ValidD}, {31'b0, v});
    chk({n, " PCD"}, PCD, pcd);
    chk({n, " InstrD"}, InstrD, ins);
    chk({n, " PCPlus8D"}, PCPlus8D, pc8);
    chk({n, " PC"}, PC, pc);
    chk({n, " FetchCount"}, FetchCount, cnt);
  endtask
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hE1A0_0000 | i;
    mem[0] = 32'hE59F_1204;
    mem[1] = 32'hE59F_9204;
    mem[12] = 32'h0;
    vt[0]  = '{1, 0, 32'h0,        0, 32'h0,        32'h0,         32'h0,  32'h0,        0};
    vt[1]  = '{1, 0, 32'h0,        1, 32'h0,        32'hE59F_1204, 32'h8,  32'h4,        0};
    vt[2]  = '{1, 0, 32'h0,        1, 32'h4,        32'hE59F_9204, 32'hC,  32'h8,        1};
    vt[3]  = '{1, 0, 32'h0,        1, 32'h8,        32'hE1A0_0002, 32'h10, 32'hC,        2};
    vt[4]  = '{0, 0, 32'h0,        1, 32'h8,        32'hE1A0_0002, 32'h10, 32'hC,        2};
    vt[5]  = '{0, 0, 32'h0,        1, 32'h8,        32'hE1A0_0002, 32'h10, 32'hC,        2};
    vt[6]  = '{0, 0, 32'h0,        1, 32'h8,        32'hE1A0_0002, 32'h10, 32'hC,        2};
    vt[7]  = '{1, 0, 32'h0,        1, 32'hC,        32'hE1A0_0003, 32'h14, 32'h10,       3};
    vt[8]  = '{0, 0, 32'h0,        1, 32'hC,        32'hE1A0_0003, 32'h14, 32'h10,       3};
    vt[9]  = '{0, 1, 32'h13,       0, 32'hC,        32'hE1A0_0003, 32'h14, 32'h10,       3};
    vt[10] = '{1, 0, 32'h0,        1, 32'h10,       32'hE1A0_0004, 32'h18, 32'h14,       3};
    vt[11] = '{1, 0, 32'h0,        1, 32'h14,       32'hE1A0_0005, 32'h1C, 32'h18,       4};
    vt[12] = '{1, 0, 32'h0,        1, 32'h18,       32'hE1A0_0006, 32'h20, 32'h1C,       5};
    vt[13] = '{1, 1, 32'h14,       0, 32'h18,       32'hE1A0_0006, 32'h20, 32'h14,       6};
    vt[14] = '{1, 0, 32'h0,        1, 32'h14,       32'hE1A0_0005, 32'h1C, 32'h18,       6};
    vt[15] = '{1, 0, 32'h0,        1, 32'h18,       32'hE1A0_0006, 32'h20, 32'h1C,       7};
    vt[16] = '{1, 1, 32'h14,       0, 32'h18,       32'hE1A0_0006, 32'h20, 32'h14,       8};
    vt[17] = '{1, 0, 32'h0,        1, 32'h14,       32'hE1A0_0005, 32'h1C, 32'h18,       8};
    vt[18] = '{1, 1, 32'hFFFF_FFFC, 0, 32'h14,      32'hE1A0_0005, 32'h1C, 32'hFFFF_FFFC, 9};
    vt[19] = '{1, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hE1A0_007F, 32'h4, 32'h0,        9};
    vt[20] = '{1, 0, 32'h0,        1, 32'h0,        32'hE59F_1204, 32'h8,  32'h4,        10};
    Reset = 1'b1; Redirect = 1'b0; RedirectTarget = '0; ReadyD = 1'b1;
    repeat (2) step();
    chk_all("reset", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    chk("reset Halted", {31'b0, Halted}, 32'h0);
    Reset = 1'b0;
    for (int i = 0; i < 21; i++) begin
      ReadyD = vt[i].rdy;
      Redirect = vt[i].red;
      RedirectTarget = vt[i].tgt;
      step();
      chk_all($sformatf("v%0d", i), vt[i].v, vt[i].pcd, vt[i].ins, vt[i].pc8, vt[i].pc, vt[i].cnt);
    end
    // reset mid-operation beats a simultaneous redirect and transfer
    Reset = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h40; ReadyD = 1'b1;
    step();
    chk_all("midreset", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    Reset = 1'b0;
    step();
    chk_all("boot_redirect", 0, 32'h0, 32'h0, 32'h0, 32'h40, 0);
    Redirect = 1'b0;
    step();
    chk_all("boot_target", 1, 32'h40, 32'hE1A0_0010, 32'h48, 32'h44, 0);
    Redirect = 1'b1; RedirectTarget = 32'h30;
    step();
    chk_all("to_word12", 0, 32'h40, 32'hE1A0_0010, 32'h48, 32'h30, 1);
    Redirect = 1'b0;
    step();
    chk_all("zero_word", 1, 32'h30, 32'h0, 32'h38, 32'h34, 1);
    step();
    chk_all("past_zero", 1, 32'h34, 32'hE1A0_000D, 32'h3C, 32'h38, 2);
    chk("no_halt Halted", {31'b0, Halted}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the ARM-subset processor, directly upstream of the decoder and driving the address of the combinational instruction memory.
- Owns the program counter and presents `PC` to instruction memory; the memory returns `Instr` in the same cycle.
- Captures `Instr`, `PC` and `PC+8` (the ARM R15 read value) into an IF/ID pipeline register.
- Hands that register to decode over a valid/ready handshake.
- Accepts branch redirects from execute.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- IMEM_WORDS, 128, instruction-memory depth in words; used only by the optional halt check.

Ports:
- CLK  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous active-high reset.
- PC  out  32  fetch address to instruction memory (word aligned).
- Instr  in  32  instruction word returned combinationally for PC.
- Redirect  in  1  execute-stage taken branch / PC write.
- RedirectTarget  in  32  new PC when Redirect=1.
- ValidD  out  1  IF/ID register holds a live instruction.
- ReadyD  in  1  decode accepts the IF/ID contents this cycle.
- InstrD  out  32  registered instruction.
- PCD  out  32  address of InstrD.
- PCPlus8D  out  32  PCD+8, modulo 2^32.
- FetchCount  out  32  number of instructions delivered to decode (handshakes).
- Halted  out  1  fetch halted (optional feature; tied 0 when compiled out).

Behaviour:
- Clock and reset: one clock `CLK`. Reset is synchronous and active-high, named `Reset`.
- Reset values:
  - PC=RESET_VECTOR, ValidD=0, InstrD=0, PCD=0, PCPlus8D=0, FetchCount=0, Halted=0.
  - state=BOOT.
  - Reset asserted mid-operation discards any held instruction and wins over Redirect and ReadyD.
- State machine:
  - BOOT: one cycle, no capture; goes to RUN unconditionally.
  - RUN: normal fetch.
  - HALT: exists only with the macro.
- Advance condition (RUN): adv = !ValidD || ReadyD.
- On adv without Redirect:
  - IF/ID <= {Instr, PC, PC+8}.
  - ValidD <= 1.
  - PC <= PC+4.
- On !adv without Redirect: PC and IF/ID hold (stall). Instr must be re-read for the same PC, so the output is stable.
- Handshake: a transfer occurs when ValidD && ReadyD; FetchCount increments by 1 on each transfer and wraps at 2^32.
  - ValidD never drops without a transfer, except on Redirect or Reset.
  - InstrD, PCD and PCPlus8D are stable while ValidD && !ReadyD.
- Redirect (highest priority after Reset, honoured in any state including stall and BOOT):
  - PC <= {RedirectTarget[31:2], 2'b00}; the low two bits are forced to zero.
  - ValidD <= 0 (flush the wrong-path instruction); no capture that cycle.
  - FetchCount still counts a transfer occurring in the same cycle.
- Latency: the first valid instruction appears 2 cycles after Reset deasserts (BOOT, then capture). After a redirect, the target instruction is valid in the next-but-one cycle (1 bubble).
- Wrap-around: PC=32'hFFFF_FFFC advances to 32'h0000_0000; PCPlus8D is computed modulo 2^32.
- Instr is treated as opaque; the fetch stage performs no decode.

Optional Feature:
- Macro name: FETCH_HALT_EN.
- Defined: in RUN, a capture where Instr==32'h0000_0000 (unfilled memory) or PC>=IMEM_WORDS*4 does the following:
  - Does not set ValidD; the current IF/ID contents still drain by handshake.
  - Holds PC.
  - Enters HALT and sets Halted=1.
- In HALT, only Redirect (back to RUN, Halted=0) or Reset leaves the state.
- Not defined: no HALT state; an all-zero word is fetched as a normal instruction; Halted is constant 0.

Decomposition:
- Shared package (proc_pkg), holding:
  - state encoding fetch_state_t {BOOT, RUN, HALT};
  - constants PC_STEP=4, PC_READ_OFFSET=8, NOP_EMPTY=32'h0.
- One natural sub-module: if_id_reg, the handshake pipeline register (valid/ready, flush, load-enable, data hold).
- PC and FSM logic stay in the top module.

Test Plan:
- Reset with ReadyD=1 held, memory word0=E59F1204, word1=E59F9204:
  - cycle 2: ValidD=1, InstrD=E59F1204, PCD=0, PCPlus8D=8.
  - cycle 3: InstrD=E59F9204, PCD=4.
  - FetchCount increments by 1 per cycle.
- ReadyD=0 for 3 cycles while ValidD=1 (held PCD=8):
  - InstrD, PCD and PC are unchanged for all 3 cycles; FetchCount is frozen.
  - After ReadyD=1, the next PCD is 12.
- Redirect=1 with RedirectTarget=32'h0000_0013 during a stall:
  - next cycle: ValidD=0, PC=0x10.
  - following cycle: ValidD=1, PCD=0x10.
- Branch-to-self (word13=EAFFFFF4 style loop) driven via Redirect to 0x14 every other cycle: PCD alternates 0x14/0x18 with one bubble each time; there are no duplicate transfers.
- PC preloaded via Redirect to 32'hFFFF_FFFC with ReadyD=1: PCD=FFFF_FFFC and PCPlus8D=0000_0004, then PCD=0000_0000.
- With FETCH_HALT_EN, fetch reaches word12=0:
  - Halted=1 and PC holds at 0x30; the last valid instruction drains; ValidD then stays 0.
  - Redirect to 0 clears Halted; Reset mid-halt returns to BOOT.
